kf76489_write_arbiter: RTL
==========================

Name: kf76489_write_arbiter

Overview:
- Two-requester write arbiter and bus sequencer for the KF76489 sound core register port.
- Accepts byte write requests from two masters (e.g. CPU and a music-replay engine), then serialises them onto CE_N/WE_N/D_IN with programmable strobe and recovery timing.
- Never interleaves the two-byte tone-frequency sequence (latch byte, then data byte) of one requester with bytes from the other.

Parameters:
- STROBE_CYCLES, 2, clocks WE_N held low before READY is sampled (min 1).
- GAP_CYCLES, 2, clocks with CE_N/WE_N high between writes (0 allowed).
- LOCK_TIMEOUT, 256, clocks a frequency lock may stay idle before forced release (used only with the optional feature).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 has a byte
- req0_data  in  8  requester 0 byte
- req0_ready  out  1  1-cycle pulse; req0 byte accepted this cycle
- req1_valid  in  1  requester 1 has a byte
- req1_data  in  8  requester 1 byte
- req1_ready  out  1  1-cycle pulse; req1 byte accepted this cycle
- CE_N  out  1  chip enable to sound core, active low
- WE_N  out  1  write enable to sound core, active low
- D_OUT  out  8  data to sound core D_IN
- READY_IN  in  1  sound core READY
- busy  out  1  FSM not in IDLE
- locked  out  1  frequency lock active
- lock_owner  out  1  requester holding the lock

Behaviour:
- Reset: CE_N=1, WE_N=1, D_OUT=0, reqN_ready=0, busy=0, locked=0, lock_owner=0, rr pointer=0. FSM=IDLE, counters=0.
- Reset mid-operation: the strobe is abandoned on the edge after reset is sampled. No ready pulse is produced for the aborted byte.
- FSM states: IDLE, SETUP, STROBE, WAIT_RDY, RECOVER.
- IDLE: choose a requester, pulse its reqN_ready, and register its data into D_OUT; go to SETUP.
  - Locked: only lock_owner is eligible; the other requester is stalled.
  - Unlocked, both valid: round-robin; the pointer flips to the non-granted requester after each grant.
  - Unlocked, one valid: that requester.
- SETUP: 1 clock with CE_N=0, WE_N=1; then STROBE.
- STROBE: CE_N=0, WE_N=0 for STROBE_CYCLES clocks; then WAIT_RDY.
- WAIT_RDY: hold CE_N=0, WE_N=0 until READY_IN=1 is sampled.
  - On READY_IN=1: next cycle CE_N=1, WE_N=1. Go to RECOVER, or to IDLE if GAP_CYCLES=0.
- RECOVER: CE_N=1, WE_N=1 for GAP_CYCLES clocks; then IDLE.
- Minimum grant-to-grant spacing: 1+1+STROBE_CYCLES+GAP_CYCLES clocks, plus any READY wait.
- Lock rules, evaluated when a byte is granted:
  - Set lock (owner = granted requester): byte[7]=1, byte[4]=0 and byte[6:5]!=2'b11, i.e. a tone 1-3 frequency latch.
  - Release lock: byte[7]=0 from the owner.
  - Any other latch byte from the owner (attenuation or noise): clears the lock.
  - The lock changes state in the cycle the grant pulse is asserted. The locked output reflects it from the next cycle.
- Round-robin pointer is not advanced by locked grants. After unlock it points to the non-owner.
- D_OUT holds its value after a write until the next grant.
- reqN_data is sampled only on the grant cycle; the requester may change it afterwards.
- A requester deasserting reqN_valid while not granted is legal; no state is kept for it.

Optional Feature:
- Macro KF76489_WRITE_ARB_LOCK_TIMEOUT_EN.
- Defined: a counter clears on every owner grant and increments each clock while locked and in IDLE with no owner request. When it reaches LOCK_TIMEOUT, the lock is released (locked=0) and normal round-robin resumes.
- Undefined: no counter; the lock is held until the owner's data byte, the owner's next non-frequency latch byte, or reset.

Test Plan:
- Single write: req0 sends 0x9F, READY_IN tied 1 → req0_ready pulses once. CE_N low for 1+2 clocks with WE_N low the last 2 clocks and D_OUT=0x9F. Idle again after 2 gap clocks; busy tracks exactly.
- Round-robin: both valid continuously, req0=0x90, req1=0xB0 → grants alternate 0,1,0,1 with no back-to-back grant to the same requester.
- Lock: req0 sends 0x81 then 0x0A after a 10-clock delay, req1 held valid with 0xBF → sequence 0x81, 0x0A, 0xBF. locked=1 between the first two grants and lock_owner=0.
- Non-locking latch: req0 0xE4 (noise) and req0 0x9F (attenuation), req1 valid → no lock; req1 is granted between them.
- READY stall: READY_IN=0 for 20 clocks after the strobe → WE_N and CE_N stay low until READY_IN=1, then both go high the next clock. No new grant during the stall.
- Reset and timeout: assert reset during STROBE → CE_N/WE_N high and all outputs at reset values next edge. With macro and LOCK_TIMEOUT=16, req0 sends 0xA5 and then stops, req1 valid → locked drops after 16 idle clocks and req1 is granted.

Source files
------------

// File: rtl/kf76489_write_arbiter.sv
// kf76489_write_arbiter: two-requester byte write arbiter and CE_N/WE_N bus sequencer for the KF76489 register port.
// Optional idle-lock timeout is enabled by defining KF76489_WRITE_ARB_LOCK_TIMEOUT_EN.
module kf76489_write_arbiter #(
    parameter int STROBE_CYCLES = 2,
    parameter int GAP_CYCLES    = 2,
    parameter int LOCK_TIMEOUT  = 256
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       CE_N,
    output logic       WE_N,
    output logic [7:0] D_OUT,
    input  logic       READY_IN,
    output logic       busy,
    output logic       locked,
    output logic       lock_owner
);
    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STROBE, S_WAIT_RDY, S_RECOVER} state_t;

    localparam int CMAX = (STROBE_CYCLES > GAP_CYCLES) ? STROBE_CYCLES : GAP_CYCLES;
    localparam int CW = $clog2(CMAX + 1);
    localparam logic [CW-1:0] S_LAST = CW'(STROBE_CYCLES - 1);
    localparam logic [CW-1:0] G_LAST = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam state_t AFTER_WRITE = (GAP_CYCLES == 0) ? S_IDLE : S_RECOVER;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_rr;
    logic            r_locked;
    logic            r_owner;
    logic            w_elig0;
    logic            w_elig1;
    logic            w_gnt0;
    logic            w_gnt1;
    logic [7:0]      w_byte;
    logic            w_freq;
    logic            w_to_expire;

    // While locked only the owner may be granted; otherwise the rr pointer breaks ties.
    assign w_elig0 = req0_valid && (!r_locked || !r_owner);
    assign w_elig1 = req1_valid && (!r_locked || r_owner);
    assign w_gnt0  = !reset && r_state == S_IDLE && w_elig0 && (!w_elig1 || !r_rr);
    assign w_gnt1  = !reset && r_state == S_IDLE && w_elig1 && !w_gnt0;
    assign w_byte  = w_gnt1 ? req1_data : req0_data;
    assign w_freq  = w_byte[7] && !w_byte[4] && (w_byte[6:5] != 2'b11);

    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;
    assign busy       = r_state != S_IDLE;
    assign locked     = r_locked;
    assign lock_owner = r_owner;

`ifdef KF76489_WRITE_ARB_LOCK_TIMEOUT_EN
    localparam int TW = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [TW-1:0] T_LAST = TW'(LOCK_TIMEOUT - 1);
    logic [TW-1:0] r_to_cnt;
    logic          w_to_inc;
    assign w_to_inc    = r_locked && r_state == S_IDLE && !(r_owner ? req1_valid : req0_valid);
    assign w_to_expire = w_to_inc && r_to_cnt == T_LAST;
    always_ff @(posedge clock) begin
        if (reset || w_gnt0 || w_gnt1 || w_to_expire)
            r_to_cnt <= '0;
        else if (w_to_inc)
            r_to_cnt <= r_to_cnt + 1'b1;
    end
`else
    assign w_to_expire = LOCK_TIMEOUT < 0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            CE_N     <= 1'b1;
            WE_N     <= 1'b1;
            D_OUT    <= 8'h00;
            r_rr     <= 1'b0;
            r_locked <= 1'b0;
            r_owner  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_gnt0 || w_gnt1) begin
                        D_OUT    <= w_byte;
                        CE_N     <= 1'b0;
                        r_state  <= S_SETUP;
                        r_locked <= w_freq;
                        if (w_freq)
                            r_owner <= w_gnt1;
                        if (!r_locked)
                            r_rr <= w_gnt0;
                    end else if (w_to_expire) begin
                        r_locked <= 1'b0;
                    end
                end
                S_SETUP: begin
                    WE_N    <= 1'b0;
                    r_cnt   <= '0;
                    r_state <= S_STROBE;
                end
                // READY is sampled on the last strobe clock so a ready core costs no extra cycle.
                S_STROBE: begin
                    if (r_cnt == S_LAST) begin
                        if (READY_IN) begin
                            CE_N    <= 1'b1;
                            WE_N    <= 1'b1;
                            r_cnt   <= '0;
                            r_state <= AFTER_WRITE;
                        end else begin
                            r_state <= S_WAIT_RDY;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_WAIT_RDY: begin
                    if (READY_IN) begin
                        CE_N    <= 1'b1;
                        WE_N    <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= AFTER_WRITE;
                    end
                end
                S_RECOVER: begin
                    if (r_cnt == G_LAST)
                        r_state <= S_IDLE;
                    else
                        r_cnt <= r_cnt + 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
